// File: rtl/board_pkg.sv
// Shared codes, VGA timing defaults, pixel-pipeline payloads and the card palette
// for the board display path.
package board_pkg;

  localparam int unsigned HC_W  = 10;
  localparam int unsigned VC_W  = 10;
  localparam int unsigned OFF_W = 7;
  localparam int unsigned RGB_W = 24;

  // 640x480@60 timing
  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;

  localparam logic [3:0] CS_HIDDEN     = 4'd0;
  localparam logic [3:0] CS_MATCHED_P1 = 4'd9;
  localparam logic [3:0] CS_MATCHED_P2 = 4'd10;

  localparam logic [2:0] GS_P1_WIN = 3'd4;
  localparam logic [2:0] GS_P2_WIN = 3'd5;

  localparam logic [RGB_W-1:0] BLACK_RGB = 24'h000000;
  localparam logic [RGB_W-1:0] BG_RGB    = 24'h202020;
  localparam logic [RGB_W-1:0] P1_RGB    = 24'h0000FF;
  localparam logic [RGB_W-1:0] P2_RGB    = 24'hFF0000;
  localparam logic [RGB_W-1:0] WIN_RGB   = 24'hFFD700;

  typedef struct packed {
    logic             hit;
    logic [1:0]       idx;
    logic [OFF_W-1:0] off;
  } axis_hit_t;

  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       bar;
    logic       in_cell;
    logic       rim;
    logic [3:0] idx;
  } pix_info_t;

  function automatic logic [RGB_W-1:0] palette(input logic [3:0] cs);
    logic [RGB_W-1:0] c;
    c = 24'hFF00FF;
    case (cs)
      CS_HIDDEN:     c = 24'hFFFFFF;
      4'd1:          c = 24'hFF8000;
      4'd2:          c = 24'hFFFF00;
      4'd3:          c = 24'h00FF00;
      4'd4:          c = 24'h00FFFF;
      4'd5:          c = 24'h8000FF;
      4'd6:          c = 24'hFF0080;
      4'd7:          c = 24'h808000;
      4'd8:          c = 24'h008080;
      CS_MATCHED_P1: c = 24'h8080FF;
      CS_MATCHED_P2: c = 24'hFF8080;
      default:       c = 24'hFF00FF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and raster counters; sync/active flags are registered
// alongside the counters so they always describe the current counter value.
module vga_timing
  import board_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D
) (
  input  logic            clk,
  input  logic            rst,
  output logic            pe_o,
  output logic [HC_W-1:0] hcount_o,
  output logic [VC_W-1:0] vcount_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            active_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pe_q, pe_d;
  logic [HC_W-1:0]  h_q, h_d;
  logic [VC_W-1:0]  v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d;

  always_comb begin
    div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
    pe_d  = (div_d == DIV_W'(CLK_DIV - 1));
    h_d   = h_q;
    v_d   = v_q;
    if (pe_q) begin
      if (h_q == HC_W'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VC_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hs_d  = !((h_d >= HC_W'(H_ACTIVE + H_FP)) && (h_d < HC_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs_d  = !((v_d >= VC_W'(V_ACTIVE + V_FP)) && (v_d < VC_W'(V_ACTIVE + V_FP + V_SYNC)));
    act_d = (h_d < HC_W'(H_ACTIVE)) && (v_d < VC_W'(V_ACTIVE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      pe_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b1;
    end else begin
      div_q <= div_d;
      pe_q  <= pe_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
    end
  end

  assign pe_o     = pe_q;
  assign hcount_o = h_q;
  assign vcount_o = v_q;
  assign hsync_o  = hs_q;
  assign vsync_o  = vs_q;
  assign active_o = act_q;

endmodule

// File: rtl/vga_board_renderer.sv
// Renders the 4x4 card grid, cursor outline and status bar from a once-per-frame
// board snapshot; two pixel-enable pipeline stages between counters and pins.
module vga_board_renderer
  import board_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CELL     = 100,
  parameter int unsigned GAP      = 10,
  parameter int unsigned X0       = 100,
  parameter int unsigned Y0       = 10,
  parameter int unsigned BORDER   = 4,
  parameter int unsigned BAR_Y    = 460,
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cards,
  input  logic [3:0]  cursor,
  input  logic        player,
  input  logic [2:0]  game_state,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);

  localparam int unsigned PITCH   = CELL + GAP;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam pix_info_t   S1_RST  = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1, bar: 1'b0,
                                      in_cell: 1'b0, rim: 1'b0, idx: 4'd0};

  logic            pe, t_hs, t_vs, t_act;
  logic [HC_W-1:0] hcount;
  logic [VC_W-1:0] vcount;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .pe_o(pe), .hcount_o(hcount), .vcount_o(vcount),
    .hsync_o(t_hs), .vsync_o(t_vs), .active_o(t_act)
  );

  // Compare chain over the four cell positions along one axis.
  function automatic axis_hit_t axis_hit(input logic [HC_W-1:0] c, input int unsigned base);
    axis_hit_t h;
    h = '0;
    for (int i = 0; i < 4; i++) begin
      if ((32'(c) >= base + i * PITCH) && (32'(c) < base + i * PITCH + CELL)) begin
        h.hit = 1'b1;
        h.idx = 2'(i);
        h.off = OFF_W'(32'(c) - base - i * PITCH);
      end
    end
    return h;
  endfunction

  logic [63:0]      snap_cards_q, snap_cards_d;
  logic [3:0]       snap_cur_q, snap_cur_d;
  logic             snap_ply_q, snap_ply_d;
  logic [2:0]       snap_gs_q, snap_gs_d;
  logic             fs_q, fs_d, snap_c;
  axis_hit_t        hx, hy;
  pix_info_t        s1_q, s1_d;
  logic [RGB_W-1:0] rgb_q, rgb_d, pix, ply_rgb;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic [3:0]       nib;

  always_comb begin
    snap_c       = pe && (hcount == HC_W'(H_TOTAL - 1)) && (vcount == VC_W'(V_TOTAL - 1));
    snap_cards_d = snap_c ? cards      : snap_cards_q;
    snap_cur_d   = snap_c ? cursor     : snap_cur_q;
    snap_ply_d   = snap_c ? player     : snap_ply_q;
    snap_gs_d    = snap_c ? game_state : snap_gs_q;
    fs_d         = snap_c;
  end

  // Stage 1: hit test and sync/active alignment.
  always_comb begin
    hx   = axis_hit(hcount, X0);
    hy   = axis_hit(HC_W'(vcount), Y0);
    s1_d = s1_q;
    if (pe) begin
      s1_d.active  = t_act;
      s1_d.hsync   = t_hs;
      s1_d.vsync   = t_vs;
      s1_d.bar     = (vcount >= VC_W'(BAR_Y));
      s1_d.in_cell = hx.hit && hy.hit;
      s1_d.idx     = {hy.idx, hx.idx};
      s1_d.rim     = (hx.off < OFF_W'(BORDER)) || (hx.off >= OFF_W'(CELL - BORDER)) ||
                     (hy.off < OFF_W'(BORDER)) || (hy.off >= OFF_W'(CELL - BORDER));
    end
  end

  // Stage 2: colour by priority.
  always_comb begin
    rgb_d   = rgb_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    nib     = snap_cards_q[{s1_q.idx, 2'b00} +: 4];
    ply_rgb = snap_ply_q ? P2_RGB : P1_RGB;
    pix     = BG_RGB;
    if (!s1_q.active) begin
      pix = BLACK_RGB;
    end else if (s1_q.bar) begin
      pix = ((snap_gs_q == GS_P1_WIN) || (snap_gs_q == GS_P2_WIN)) ? WIN_RGB : ply_rgb;
    end else if (s1_q.in_cell && s1_q.rim && (s1_q.idx == snap_cur_q)) begin
      pix = ply_rgb;
    end else if (s1_q.in_cell) begin
      pix = palette(nib);
    end
    if (pe) begin
      rgb_d = pix;
      hs_d  = s1_q.hsync;
      vs_d  = s1_q.vsync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_cards_q <= {16{CS_HIDDEN}};
      snap_cur_q   <= '0;
      snap_ply_q   <= 1'b0;
      snap_gs_q    <= '0;
      fs_q         <= 1'b0;
      s1_q         <= S1_RST;
      rgb_q        <= BLACK_RGB;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
    end else begin
      snap_cards_q <= snap_cards_d;
      snap_cur_q   <= snap_cur_d;
      snap_ply_q   <= snap_ply_d;
      snap_gs_q    <= snap_gs_d;
      fs_q         <= fs_d;
      s1_q         <= s1_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench: a scaled-raster instance for multi-frame behaviour and a
// default 640x480 instance for line timing and early-grid pixels.
module tb_vga_board_renderer;
  import board_pkg::*;

  localparam int S_HT = 80;
  localparam int S_FR = 4800;
  localparam int D_HT = 800;

  logic        clk, rst;
  logic [63:0] cards;
  logic [3:0]  cursor;
  logic        player;
  logic [2:0]  game_state;
  logic        hs_s, vs_s, fs_s, hs_d, vs_d, fs_d;
  logic [7:0]  r_s, g_s, b_s, r_d, g_d, b_d;

  int errors = 0;
  int checks = 0;
  int cyc;
  int fs_count = 0;
  int fs_bad   = 0;
  int fs_last  = 0;

  vga_board_renderer #(
    .CLK_DIV(2), .CELL(10), .GAP(2), .X0(10), .Y0(2), .BORDER(2), .BAR_Y(50),
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(54), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .rst(rst), .cards(cards), .cursor(cursor), .player(player),
    .game_state(game_state), .hsync(hs_s), .vsync(vs_s), .r(r_s), .g(g_s), .b(b_s),
    .frame_start(fs_s)
  );

  vga_board_renderer dut_d (
    .clk(clk), .rst(rst), .cards(cards), .cursor(cursor), .player(player),
    .game_state(game_state), .hsync(hs_d), .vsync(vs_d), .r(r_d), .g(g_d), .b(b_d),
    .frame_start(fs_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      fs_last = 0;
    end else if (fs_s) begin
      fs_count++;
      if (fs_last != 0 && (cyc - fs_last) != 2 * S_FR) fs_bad++;
      fs_last = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    if (cyc > target) begin
      errors++;
      $display("FAIL schedule target=%0d cyc=%0d", target, cyc);
    end
    while (cyc < target) @(negedge clk);
  endtask

  // Pixel p reaches the pins after clk edge 2p+4 (divider lead + 2-stage pipe).
  task automatic px_s(input int f, input int x, input int y, input logic [23:0] exp, input string tag);
    wait_cyc(2 * (f * S_FR + y * S_HT + x) + 4);
    check(tag, {r_s, g_s, b_s}, exp);
  endtask

  task automatic hs_at_s(input int x, input int y, input logic exp, input string tag);
    wait_cyc(2 * (y * S_HT + x) + 4);
    check(tag, 24'(hs_s), 24'(exp));
  endtask

  task automatic vs_at_s(input int x, input int y, input logic exp, input string tag);
    wait_cyc(2 * (y * S_HT + x) + 4);
    check(tag, 24'(vs_s), 24'(exp));
  endtask

  task automatic px_d(input int x, input int y, input logic [23:0] exp, input string tag);
    wait_cyc(2 * (y * D_HT + x) + 4);
    check(tag, {r_d, g_d, b_d}, exp);
  endtask

  task automatic hs_at_d(input int x, input logic exp, input string tag);
    wait_cyc(2 * x + 4);
    check(tag, 24'(hs_d), 24'(exp));
  endtask

  initial begin
    rst = 1'b0; cards = '0; cursor = 4'd0; player = 1'b0; game_state = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_hsync", 24'(hs_s), 24'd1);
    check("rst_vsync", 24'(vs_s), 24'd1);
    check("rst_rgb", {r_s, g_s, b_s}, 24'h000000);
    check("rst_fs", 24'(fs_s), 24'd0);
    check("rst_rgb_full", {r_d, g_d, b_d}, 24'h000000);
    rst = 1'b1;

    // Frame 0: reset snapshot (all hidden, cursor 0, player 0).
    hs_at_s(67, 1, 1'b1, "hs_before_sync");
    hs_at_s(68, 1, 1'b0, "hs_sync_first");
    hs_at_s(75, 1, 1'b0, "hs_sync_last");
    hs_at_s(76, 1, 1'b1, "hs_after_sync");
    px_s(0, 10, 2, 24'h0000FF, "f0_cursor_rim");
    px_s(0, 5, 7, 24'h202020, "f0_left_of_grid");
    px_s(0, 15, 7, 24'hFFFFFF, "f0_cell0_hidden");
    px_s(0, 20, 7, 24'h202020, "f0_gap");
    px_s(0, 70, 7, 24'h000000, "f0_blanking");
    hs_at_d(655, 1'b1, "full_hs_655");
    hs_at_d(656, 1'b0, "full_hs_656");
    hs_at_d(751, 1'b0, "full_hs_751");
    hs_at_d(752, 1'b1, "full_hs_752");

    wait_cyc(2 * (12 * S_HT) + 4);
    cards = '0; cards[23:20] = 4'd3;
    cursor = 4'd15; player = 1'b1; game_state = GS_P2_WIN;

    px_s(0, 27, 19, 24'hFFFFFF, "f0_card5_unchanged");
    px_s(0, 46, 38, 24'hFFFFFF, "f0_cell15_no_rim");
    px_s(0, 15, 49, 24'h202020, "f0_below_grid");
    px_s(0, 15, 51, 24'h0000FF, "f0_bar_p1");
    vs_at_s(0, 55, 1'b1, "vs_before_sync");
    vs_at_s(0, 56, 1'b0, "vs_sync_first");
    vs_at_s(79, 57, 1'b0, "vs_sync_last");
    vs_at_s(0, 58, 1'b1, "vs_after_sync");
    wait_cyc(2 * S_FR - 1);
    check("fs_before", 24'(fs_s), 24'd0);
    wait_cyc(2 * S_FR);
    check("fs_pulse", 24'(fs_s), 24'd1);
    wait_cyc(2 * S_FR + 1);
    check("fs_after", 24'(fs_s), 24'd0);

    // Frame 1: card5=3, cursor 15, player 1, P2 win.
    px_s(1, 10, 2, 24'hFFFFFF, "f1_cell0_no_rim");
    px_s(1, 27, 19, 24'h00FF00, "f1_card5_pal3");
    px_s(1, 46, 38, 24'hFF0000, "f1_rim15_topleft");
    px_s(1, 51, 43, 24'hFFFFFF, "f1_cell15_inner");
    px_s(1, 55, 47, 24'hFF0000, "f1_rim15_botright");
    px_s(1, 15, 51, 24'hFFD700, "f1_bar_win");
    px_d(101, 11, 24'h0000FF, "full_rim_101_11");

    cards = '0;
    cards[3:0] = CS_MATCHED_P1; cards[7:4] = CS_MATCHED_P2;
    cards[11:8] = 4'd12; cards[15:12] = 4'd8; cards[23:20] = 4'd3;
    cursor = 4'd5; player = 1'b0; game_state = GS_P1_WIN;

    // Frame 2: palette variety, cursor on cell 5 with P1 colour.
    px_s(2, 15, 7, 24'h8080FF, "f2_matched_p1");
    px_s(2, 27, 7, 24'hFF8080, "f2_matched_p2");
    px_s(2, 39, 7, 24'hFF00FF, "f2_error_code");
    px_s(2, 51, 7, 24'h008080, "f2_label8");
    px_s(2, 22, 14, 24'h0000FF, "f2_rim5");
    px_s(2, 27, 19, 24'h00FF00, "f2_card5_inner");
    px_s(2, 15, 51, 24'hFFD700, "f2_bar_win");

    wait_cyc(3 * 2 * S_FR + 10);
    check("fs_count", 24'(fs_count), 24'd3);
    check("fs_spacing", 24'(fs_bad), 24'd0);

    px_d(99, 20, 24'h202020, "full_left_of_grid");
    px_d(150, 20, 24'hFFFFFF, "full_cell0_inner");
    px_d(205, 20, 24'h202020, "full_gap");

    // Reset mid-frame in frame 3.
    px_s(3, 15, 29, 24'hFFFFFF, "f3_before_reset");
    wait_cyc(2 * (3 * S_FR + 30 * S_HT) + 4);
    rst = 1'b0;
    #1;
    check("mid_rst_rgb", {r_s, g_s, b_s}, 24'h000000);
    check("mid_rst_hsync", 24'(hs_s), 24'd1);
    check("mid_rst_vsync", 24'(vs_s), 24'd1);
    repeat (3) @(negedge clk);
    check("mid_rst_rgb_hold", {r_s, g_s, b_s}, 24'h000000);
    check("mid_rst_fs", 24'(fs_s), 24'd0);
    rst = 1'b1;

    hs_at_s(67, 1, 1'b1, "rr_hs_before_sync");
    hs_at_s(68, 1, 1'b0, "rr_hs_sync_first");
    px_s(0, 10, 2, 24'h0000FF, "rr_cursor_rim");
    hs_at_d(656, 1'b0, "rr_full_hs_656");
    px_s(0, 27, 19, 24'hFFFFFF, "rr_card5_hidden");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
